// File: rtl/instruction_fetch_queue_if.sv
// Control and decode-side bundle of the instruction fetch queue.
// Optional build macro: IFQ_REDIRECT_CNT_EN adds o_redirect_count.
// The slave modport is the fetch queue; the master modport is whoever drives
// redirect, ready and the program-load port and consumes the queue head.
interface instruction_fetch_queue_if #(
    parameter int SIZE       = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                  i_redirect;
    logic [SIZE-1:0]       i_redirect_pc;
    logic                  i_ready;
    logic                  i_inst_write_enable;
    logic [ADDR_WIDTH-1:0] i_write_addr;
    logic [SIZE-1:0]       i_write_data;
    logic                  o_valid;
    logic [SIZE-1:0]       o_instruction;
    logic [SIZE-1:0]       o_pc;
    logic [SIZE-1:0]       o_pc_next;
    logic                  o_full;
    logic                  o_empty;
    logic                  o_writing_instruction_mem;
`ifdef IFQ_REDIRECT_CNT_EN
    logic [15:0]           o_redirect_count;

    modport master (
        output i_redirect, i_redirect_pc, i_ready,
               i_inst_write_enable, i_write_addr, i_write_data,
        input  o_valid, o_instruction, o_pc, o_pc_next,
               o_full, o_empty, o_writing_instruction_mem, o_redirect_count
    );

    modport slave (
        input  i_redirect, i_redirect_pc, i_ready,
               i_inst_write_enable, i_write_addr, i_write_data,
        output o_valid, o_instruction, o_pc, o_pc_next,
               o_full, o_empty, o_writing_instruction_mem, o_redirect_count
    );
`else
    modport master (
        output i_redirect, i_redirect_pc, i_ready,
               i_inst_write_enable, i_write_addr, i_write_data,
        input  o_valid, o_instruction, o_pc, o_pc_next,
               o_full, o_empty, o_writing_instruction_mem
    );

    modport slave (
        input  i_redirect, i_redirect_pc, i_ready,
               i_inst_write_enable, i_write_addr, i_write_data,
        output o_valid, o_instruction, o_pc, o_pc_next,
               o_full, o_empty, o_writing_instruction_mem
    );
`endif
endinterface

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch stage: instruction memory, fetch PC and a small FIFO of
// {pc, instruction} entries drained by decode over a valid/ready handshake.
// A redirect flushes the queue and refetches from the target; holding the
// program-load enable writes memory, flushes the queue and parks fetch at 0.
// Optional build macro: IFQ_REDIRECT_CNT_EN adds a saturating redirect counter.
// The interface instance must use the same SIZE and ADDR_WIDTH as this module.
module instruction_fetch_queue #(
    parameter int SIZE            = 32,
    parameter int MAX_INSTRUCTION = 64,
    parameter int FIFO_DEPTH      = 4,
    parameter int PC_STEP         = 1
) (
    input logic                      i_clk,
    input logic                      i_rst_n,
    instruction_fetch_queue_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(MAX_INSTRUCTION);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int SHIFT      = $clog2(PC_STEP);
    localparam int MEM_WORDS  = 1 << ADDR_WIDTH;

    typedef enum logic {RUN, LOAD} state_t;

    state_t                state_q, state_d;
    logic [SIZE-1:0]       mem       [MEM_WORDS];
    logic [SIZE-1:0]       fifo_pc   [FIFO_DEPTH];
    logic [SIZE-1:0]       fifo_inst [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr, wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [SIZE-1:0]       fetch_pc;

    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic [SIZE-1:0]       fetch_inst;
    logic [SIZE:0]         pc_inc;
    logic [SIZE-1:0]       pc_after;
    logic                  head_valid;
    logic                  flush;
    logic                  redirect_take;
    logic                  pop;
    logic                  push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Combinational fetch: index the memory by the fetch PC and work out the
    // following PC, wrapping to 0 once the next index runs past the memory.
    assign fetch_idx  = ADDR_WIDTH'(fetch_pc >> SHIFT);
    assign fetch_inst = mem[fetch_idx];
    assign pc_inc     = {1'b0, fetch_pc} + (SIZE + 1)'(PC_STEP);
    assign pc_after   = ((pc_inc >> SHIFT) >= (SIZE + 1)'(MAX_INSTRUCTION))
                        ? '0 : pc_inc[SIZE-1:0];
    assign head_valid = (count != '0);

    // Load-mode state register; the registered state is the load indicator.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= RUN;
        else          state_q <= state_d;
    end

    // Next state and per-edge queue actions. A high load enable always wins
    // (even on the RUN edge that enters LOAD), redirects only count in RUN,
    // and the LOAD exit edge streams normally so fetch restarts at PC 0.
    always_comb begin
        state_d       = state_q;
        flush         = 1'b0;
        redirect_take = 1'b0;
        pop           = 1'b0;
        push          = 1'b0;
        if (bus.i_inst_write_enable) begin
            state_d = LOAD;
            flush   = 1'b1;
        end else begin
            state_d = RUN;
            if (state_q == RUN && bus.i_redirect) begin
                redirect_take = 1'b1;
            end else begin
                pop  = head_valid & bus.i_ready;
                push = (count != CNT_W'(FIFO_DEPTH)) | pop;
            end
        end
    end

    // Queue bookkeeping and fetch PC. Push always accompanies pop, so the
    // occupancy can only grow or hold while streaming.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fetch_pc <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (flush || redirect_take) begin
            fetch_pc <= redirect_take ? bus.i_redirect_pc : '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push) begin
                wr_ptr   <= ptr_inc(wr_ptr);
                fetch_pc <= pc_after;
            end
            if (push && !pop) count <= count + 1'b1;
        end
    end

    // Queue storage; contents are only visible through a nonzero count.
    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= fetch_pc;
            fifo_inst[wr_ptr] <= fetch_inst;
        end
    end

    // Program-load write port; memory contents survive reset.
    always_ff @(posedge i_clk) begin
        if (bus.i_inst_write_enable) mem[bus.i_write_addr] <= bus.i_write_data;
    end

`ifdef IFQ_REDIRECT_CNT_EN
    logic [15:0] redirect_count;

    // Saturating count of redirects that were acted upon.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                                    redirect_count <= '0;
        else if (redirect_take && redirect_count != 16'hFFFF) redirect_count <= redirect_count + 1'b1;
    end

    assign bus.o_redirect_count = redirect_count;
`endif

    assign bus.o_valid                   = head_valid;
    assign bus.o_instruction             = head_valid ? fifo_inst[rd_ptr] : '0;
    assign bus.o_pc                      = head_valid ? fifo_pc[rd_ptr] : '0;
    assign bus.o_pc_next                 = head_valid ? fifo_pc[rd_ptr] + SIZE'(PC_STEP) : '0;
    assign bus.o_full                    = (count == CNT_W'(FIFO_DEPTH));
    assign bus.o_empty                   = !head_valid;
    assign bus.o_writing_instruction_mem = (state_q == LOAD);
endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Testbench for instruction_fetch_queue (default parameters). A queue-based
// reference model tracks memory, fetch PC and the FIFO contents; directed
// scenarios are followed by a randomized run.
module tb_instruction_fetch_queue;
    localparam int SIZE   = 32;
    localparam int MAXI   = 64;
    localparam int DEPTH  = 4;
    localparam int STEP   = 1;
    localparam int AW     = 6;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] model_mem [MAXI];
    entry_t      model_q [$];
    logic [31:0] model_pc;
    logic        model_load;
    logic [15:0] model_rc;

    instruction_fetch_queue_if #(.SIZE(SIZE), .ADDR_WIDTH(AW)) bus ();

    instruction_fetch_queue #(
        .SIZE(SIZE), .MAX_INSTRUCTION(MAXI), .FIFO_DEPTH(DEPTH), .PC_STEP(STEP)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Model state as it must be right after reset.
    task automatic modelReset();
        model_q.delete();
        model_pc   = '0;
        model_load = 1'b0;
        model_rc   = '0;
    endtask

    // Advance the reference model by one clock edge with the given inputs.
    task automatic modelStep(input logic redir, input logic [31:0] rpc, input logic rdy,
                             input logic we, input logic [5:0] wa, input logic [31:0] wd);
        entry_t e;
        if (we) begin
            model_mem[wa] = wd;
            model_q.delete();
            model_pc   = '0;
            model_load = 1'b1;
        end else if (!model_load && redir) begin
            model_q.delete();
            model_pc = rpc;
            if (model_rc != 16'hFFFF) model_rc = model_rc + 16'd1;
        end else begin
            model_load = 1'b0;
            if (model_q.size() > 0 && rdy) void'(model_q.pop_front());
            if (model_q.size() < DEPTH) begin
                e.pc   = model_pc;
                e.inst = model_mem[(model_pc / STEP) % MAXI];
                model_q.push_back(e);
                model_pc = model_pc + STEP;
                if (model_pc / STEP >= MAXI) model_pc = '0;
            end
        end
    endtask

    // Compare every DUT output against the model.
    task automatic compareAll();
        logic        v;
        logic [31:0] epc;
        logic [31:0] einst;
        v     = (model_q.size() != 0);
        epc   = v ? model_q[0].pc : 32'd0;
        einst = v ? model_q[0].inst : 32'd0;
        checkOutput("valid", bus.o_valid, v);
        checkOutput("instruction", bus.o_instruction, einst);
        checkOutput("pc", bus.o_pc, epc);
        checkOutput("pc_next", bus.o_pc_next, v ? epc + STEP : 32'd0);
        checkOutput("full", bus.o_full, model_q.size() == DEPTH);
        checkOutput("empty", bus.o_empty, !v);
        checkOutput("writing", bus.o_writing_instruction_mem, model_load);
`ifdef IFQ_REDIRECT_CNT_EN
        checkOutput("redirect_count", bus.o_redirect_count, model_rc);
`endif
    endtask

    // Drive one cycle of inputs, step the model, and check after the edge.
    task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic rdy,
                                 input logic we, input logic [5:0] wa, input logic [31:0] wd);
        bus.i_redirect          = redir;
        bus.i_redirect_pc       = rpc;
        bus.i_ready             = rdy;
        bus.i_inst_write_enable = we;
        bus.i_write_addr        = wa;
        bus.i_write_data        = wd;
        modelStep(redir, rpc, rdy, we, wa, wd);
        @(posedge clk);
        #1;
        compareAll();
    endtask

    initial begin
        logic [31:0] wdat;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.i_redirect          = 1'b0;
        bus.i_redirect_pc       = '0;
        bus.i_ready             = 1'b0;
        bus.i_inst_write_enable = 1'b0;
        bus.i_write_addr        = '0;
        bus.i_write_data        = '0;
        for (int i = 0; i < MAXI; i++) model_mem[i] = '0;
        modelReset();

        // Reset state.
        #2;
        compareAll();
        #11 rst_n = 1'b1;

        // Program load: A0..A3 at the bottom, random words elsewhere.
        for (int i = 0; i < MAXI; i++) begin
            wdat = (i < 4) ? 32'hA0 + i : $urandom;
            applyStimulus(1'b0, '0, 1'b0, 1'b1, 6'(i), wdat);
        end
        checkOutput("load_flag", bus.o_writing_instruction_mem, 1'b1);

        // Release with decode ready: PCs 0..3 with A0..A3 back to back.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0);
            checkOutput("t1_pc", bus.o_pc, 32'(i));
            checkOutput("t1_inst", bus.o_instruction, 32'hA0 + i);
        end

        // Back-pressure: restart at 0, stall 10 cycles, then drain 0..7.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 6'd0, 32'hA0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("t2_full", bus.o_full, 1'b1);
        checkOutput("t2_head", bus.o_pc, 32'd0);
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0);
            checkOutput("t2_drain", bus.o_pc, 32'(i));
        end

        // Redirect while full, with ready high: bubble, then target.
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, '0, '0);
        checkOutput("t3_bubble", bus.o_valid, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        checkOutput("t3_pc", bus.o_pc, 32'h20);
        checkOutput("t3_pc_next", bus.o_pc_next, 32'h21);

        // Wrap past the last word.
        applyStimulus(1'b1, 32'd62, 1'b1, 1'b0, '0, '0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0);
        checkOutput("t4_wrap0", bus.o_pc, 32'd62);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0);
        checkOutput("t4_wrap1", bus.o_pc, 32'd63);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0);
        checkOutput("t4_wrap2", bus.o_pc, 32'd0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0);
        checkOutput("t4_wrap3", bus.o_pc, 32'd1);

        // Enter load mode with a full queue, then release.
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b1, 6'd0, 32'hA0);
        checkOutput("t5_writing", bus.o_writing_instruction_mem, 1'b1);
        checkOutput("t5_valid", bus.o_valid, 1'b0);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, '0, '0);
        checkOutput("t5_restart", bus.o_pc, 32'd0);

        // Asynchronous reset between edges while streaming.
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0);
        #2 rst_n = 1'b0;
        modelReset();
        #1;
        compareAll();
        checkOutput("t6_async_valid", bus.o_valid, 1'b0);
        @(posedge clk);
        #1;
        compareAll();
        #2 rst_n = 1'b1;

`ifdef IFQ_REDIRECT_CNT_EN
        // Three redirects after reset give a count of three.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'(8 * i), 1'b1, 1'b0, '0, '0);
            applyStimulus(1'b0, '0, 1'b1, 1'b0, '0, '0);
        end
        checkOutput("t6_redirect_count", bus.o_redirect_count, 32'd3);
`endif

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 4)); k++)
                    applyStimulus(1'($urandom_range(0, 1)), 32'($urandom_range(0, MAXI - 1)),
                                  1'($urandom_range(0, 1)), 1'b1,
                                  6'($urandom_range(0, MAXI - 1)), $urandom);
            end else begin
                applyStimulus($urandom_range(0, 11) == 0, 32'($urandom_range(0, MAXI - 1)),
                              1'($urandom_range(0, 1)), 1'b0, '0, '0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
